seg7_capture_decoder: RTL and testbench

//  Receive side of the 7-seg display interface: samples an active-low segment bus
//  (e.g. a HEX0 drive looped back via GPIO), waits for it to settle, and decodes it

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_to_hex.sv | 26 ++
 rtl/seg7_capture_decoder.sv | 145 ++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table, blank pattern and the capture FSM states.
// The display encoder uses the same table so both ends of the link agree on the glyphs.
package seg7_pkg;

    // All segments off on an active-low bus
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns ordered g..a, indexed by hex value 0..F
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational classifier: maps an active-low segment pattern back to its hex value,
// flags whether it matched a glyph and whether it is the all-off blank pattern.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic [3:0] value,
    output logic       is_blank
);

    // Search the glyph table; patterns are unique so at most one entry matches
    always_comb begin
        hit   = 1'b0;
        value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == GLYPH_TABLE[i]) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

    assign is_blank = (seg_n == SEG_BLANK);

endmodule

// File: rtl/seg7_capture_decoder.sv
// Receive side of the 7-seg link: synchronizes the looped-back segment bus, waits for it
// to hold still for STABLE_CYCLES, then commits one classification (glyph/blank/invalid).
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 50_000,
    parameter int CNT_W         = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       valid,
    output logic       blank,
    output logic       invalid,
    output logic       update,
    output logic [7:0] err_count
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STABLE_CYCLES - 1);

    logic             rst_meta;
    logic             rst_sync_n;
    logic [6:0]       sync1;
    logic [6:0]       s2;
    logic [6:0]       s3;
    logic             change;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_next;
    state_t           state;
    state_t           state_next;
    logic             commit;
    logic             hit;
    logic [3:0]       value;
    logic             is_blank;

    // Board reset asserts immediately but releases on a clock edge
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Two-flop synchronizer on the segment bus plus one extra delay for change detection
    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync1 <= SEG_BLANK;
            s2    <= SEG_BLANK;
            s3    <= SEG_BLANK;
        end else begin
            sync1 <= seg_n;
            s2    <= sync1;
            s3    <= s2;
        end
    end

    assign change = (s2 != s3);

    seg7_to_hex u_seg7_to_hex (
        .seg_n    (s2),
        .hit      (hit),
        .value    (value),
        .is_blank (is_blank)
    );

    // FSM state and stability counter registers
    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state   <= SETTLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Count quiet cycles while settling; a change always restarts, even on the commit cycle
    always_comb begin
        state_next   = state;
        counter_next = counter;
        commit       = 1'b0;
        case (state)
            SETTLE: begin
                if (change) begin
                    counter_next = '0;
                end else if (counter == LAST_COUNT) begin
                    commit       = 1'b1;
                    state_next   = LOCKED;
                    counter_next = '0;
                end else begin
                    counter_next = counter + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (change) begin
                    state_next   = SETTLE;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = SETTLE;
                counter_next = '0;
            end
        endcase
    end

    // Status registers move only on a commit; update flags a new or newly valid glyph
    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            nibble    <= 4'h0;
            valid     <= 1'b0;
            blank     <= 1'b0;
            invalid   <= 1'b0;
            update    <= 1'b0;
            err_count <= 8'h00;
        end else begin
            update <= 1'b0;
            if (commit) begin
                if (hit) begin
                    update  <= (value != nibble) || !valid;
                    nibble  <= value;
                    valid   <= 1'b1;
                    blank   <= 1'b0;
                    invalid <= 1'b0;
                end else if (is_blank) begin
                    valid   <= 1'b0;
                    blank   <= 1'b1;
                    invalid <= 1'b0;
                end else begin
                    valid   <= 1'b0;
                    blank   <= 1'b0;
                    invalid <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder with STABLE_CYCLES=4.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Fixed latency: a pattern driven on a falling edge shows its status (and update pulse)
// at the 3+STABLE_CYCLES-th following falling edge, i.e. 7 with this configuration.
module tb_seg7_capture_decoder;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 4;
    localparam int LATENCY       = 3 + STABLE_CYCLES;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [6:0] seg_n;
    logic [3:0] nibble;
    logic       valid;
    logic       blank;
    logic       invalid;
    logic       update;
    logic [7:0] err_count;
    logic [15:0] dut_vec;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_capture_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .seg_n     (seg_n),
        .nibble    (nibble),
        .valid     (valid),
        .blank     (blank),
        .invalid   (invalid),
        .update    (update),
        .err_count (err_count)
    );

    assign dut_vec = {nibble, valid, blank, invalid, update, err_count};

    // Reference glyph table, g..a active-low, index = hex value
    logic [6:0] glyph_tb [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: the pattern seen by the decoder is the input delayed through a
    // three-sample pipeline; once it has been unchanged for STABLE_CYCLES cycles it is
    // reported exactly once. Reset is released two clock edges after reset_n rises.
    logic [6:0] m_p1 = 7'h7F, m_p2 = 7'h7F, m_p3 = 7'h7F;
    int         m_held = 0;
    logic [1:0] m_rstq = 2'b00;
    logic [3:0] m_nibble = 4'h0;
    logic       m_valid = 1'b0, m_blank = 1'b0, m_invalid = 1'b0, m_update = 1'b0;
    logic [7:0] m_err = 8'h00;

    function automatic logic [15:0] model_vec();
        return {m_nibble, m_valid, m_blank, m_invalid, m_update, m_err};
    endfunction

    task automatic model_reset();
        m_p1 = 7'h7F; m_p2 = 7'h7F; m_p3 = 7'h7F;
        m_held = 0;
        m_nibble = 4'h0; m_valid = 1'b0; m_blank = 1'b0; m_invalid = 1'b0;
        m_update = 1'b0; m_err = 8'h00;
    endtask

    task automatic model_commit(input logic [6:0] p);
        int idx;
        idx = -1;
        for (int i = 0; i < 16; i++) if (glyph_tb[i] == p) idx = i;
        if (idx >= 0) begin
            m_update  = (idx != int'(m_nibble)) || !m_valid;
            m_nibble  = 4'(idx);
            m_valid   = 1'b1; m_blank = 1'b0; m_invalid = 1'b0;
        end else if (p == 7'h7F) begin
            m_valid = 1'b0; m_blank = 1'b1; m_invalid = 1'b0;
        end else begin
            m_valid = 1'b0; m_blank = 1'b0; m_invalid = 1'b1;
            if (m_err < 8'd255) m_err = m_err + 8'd1;
        end
    endtask

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
            m_rstq = 2'b00;
        end else begin
            if (!m_rstq[1]) begin
                model_reset();
            end else begin
                m_update = 1'b0;
                if (m_p2 != m_p3) begin
                    m_held = 0;
                end else begin
                    m_held = m_held + 1;
                    if (m_held == STABLE_CYCLES) model_commit(m_p2);
                end
                m_p3 = m_p2; m_p2 = m_p1; m_p1 = seg_n;
            end
            m_rstq = {m_rstq[0], 1'b1};
        end
    end

    task automatic test_reset();
        int upd;
        upd = 0;
        seg_n   = 7'h7F;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (dut_vec !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, 16'h0000);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (update) upd++;
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL reset_blank_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if ({blank, valid, invalid} !== 3'b100 || upd != 0) begin
            errors++;
            $display("FAIL reset_blank_final: got blank/valid/invalid %b updates %0d expected 100 updates 0",
                     {blank, valid, invalid}, upd);
        end
    endtask

    task automatic test_zero_glyph();
        int upd, first;
        upd = 0; first = 0;
        seg_n = 7'h40;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (update) begin
                upd++;
                if (first == 0) first = i;
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL zero_glyph_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (first != LATENCY || upd != 1 || nibble !== 4'h0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_glyph_latency: got latency %0d updates %0d nibble %h valid %b expected %0d 1 0 1",
                     first, upd, nibble, valid, LATENCY);
        end
    endtask

    task automatic test_toggle();
        int upd;
        upd = 0;
        for (int t = 0; t < 10; t++) begin
            seg_n = (t % 2 == 0) ? 7'h08 : 7'h79;
            repeat (2) begin
                @(negedge CLOCK_50);
                if (update) upd++;
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL toggle_cycle: got %h expected %h", dut_vec, model_vec());
                end
            end
        end
        checks++;
        if (upd != 0 || nibble !== 4'h0) begin
            errors++;
            $display("FAIL toggle_no_commit: got updates %0d nibble %h expected 0 0", upd, nibble);
        end
        seg_n = 7'h79;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK_50);
            if (update) upd++;
        end
        checks++;
        if (upd != 1 || nibble !== 4'h1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL toggle_settle: got updates %0d nibble %h valid %b expected 1 1 1", upd, nibble, valid);
        end
    endtask

    task automatic test_reveal_frames();
        // 7'h78 would decode as the digit 7, so the last frame lights a-d instead
        logic [6:0] frames [3] = '{7'h7E, 7'h7C, 7'h70};
        for (int f = 0; f < 3; f++) begin
            seg_n = frames[f];
            repeat (6) begin
                @(negedge CLOCK_50);
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL reveal_cycle: got %h expected %h", dut_vec, model_vec());
                end
            end
        end
        repeat (6) @(negedge CLOCK_50);
        checks++;
        if (invalid !== 1'b1 || valid !== 1'b0 || err_count !== 8'd3 || nibble !== 4'h1) begin
            errors++;
            $display("FAIL reveal_final: got invalid %b valid %b err %0d nibble %h expected 1 0 3 1",
                     invalid, valid, err_count, nibble);
        end
    endtask

    task automatic test_glitch();
        int upd;
        upd = 0;
        for (int ph = 0; ph < 3; ph++) begin
            seg_n = (ph == 1) ? 7'h00 : 7'h12;
            repeat ((ph == 1) ? 2 : 12) begin
                @(negedge CLOCK_50);
                if (update) upd++;
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL glitch_cycle: got %h expected %h", dut_vec, model_vec());
                end
            end
        end
        checks++;
        if (upd != 1 || nibble !== 4'h5 || valid !== 1'b1) begin
            errors++;
            $display("FAIL glitch_final: got updates %0d nibble %h valid %b expected 1 5 1", upd, nibble, valid);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1)      seg_n = glyph_tb[$urandom_range(0, 15)];
            else if (kind == 2) seg_n = 7'h7F;
            else                seg_n = 7'($urandom);
            repeat ($urandom_range(1, 10)) begin
                @(negedge CLOCK_50);
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL random_%0d: seg %h got %h expected %h", n, seg_n, dut_vec, model_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 302; n++) begin
            seg_n = (n % 2 == 0) ? 7'h7E : 7'h7C;
            repeat (7) begin
                @(negedge CLOCK_50);
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL saturation_%0d: got %h expected %h", n, dut_vec, model_vec());
                end
            end
        end
        repeat (8) @(negedge CLOCK_50);
        checks++;
        if (err_count !== 8'd255 || invalid !== 1'b1) begin
            errors++;
            $display("FAIL saturation_final: got err %0d invalid %b expected 255 1", err_count, invalid);
        end
    endtask

    task automatic test_reset_mid_settle();
        seg_n = 7'h40;
        repeat (4) @(negedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_settle: got %h expected %h", dut_vec, 16'h0000);
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLOCK_50);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL after_reset_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (nibble !== 4'h0 || valid !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL after_reset_final: got nibble %h valid %b err %0d expected 0 1 0",
                     nibble, valid, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_zero_glyph();
        test_toggle();
        test_reveal_frames();
        test_glitch();
        test_random();
        test_saturation();
        test_reset_mid_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
